// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: run-time pattern/length, overlap or
// non-overlap matching, Mealy and registered match flags, saturating count.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic               z_q,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_RST   = LEN_W'(4);
  localparam logic [MAX_LEN-1:0] PAT_RST   = MAX_LEN'(4'b0110);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               z_q_r;

  logic               accept_s;
  logic [MAX_LEN-1:0] window_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               fill_ok_s;
  logic               z_s;
  logic [LEN_W-1:0]   len_clamp_s;
  logic [LEN_W-1:0]   fill_next_s;
  logic [CNT_W-1:0]   cnt_next_s;

  assign accept_s  = x_valid & ~cfg_load;
  assign window_s  = {hist_r[MAX_LEN-2:0], x};
  // fill + 1 >= len avoids the underflow of len - 1 when len is zero
  assign fill_ok_s = (({1'b0, fill_r} + (LEN_W+1)'(1)) >= {1'b0, len_r});

  // Compare mask: only the low len_r pattern bits take part in the match
  always_comb begin
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len_r)) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  // Mealy match decision
  always_comb begin
    z_s = 1'b0;
    if (accept_s && (len_r != {LEN_W{1'b0}}) && fill_ok_s &&
        (((window_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}})) begin
      z_s = 1'b1;
    end else begin
      z_s = 1'b0;
    end
  end

  // Clamp requested length to the history depth
  always_comb begin
    len_clamp_s = cfg_len;
    if (cfg_len > LEN_MAX) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = cfg_len;
    end
  end

  // Fill counter next value: restart after a non-overlapping match, else saturate
  always_comb begin
    fill_next_s = fill_r;
    if (!accept_s) begin
      fill_next_s = fill_r;
    end else if (z_s && !ovl_r) begin
      fill_next_s = {LEN_W{1'b0}};
    end else if (fill_r == LEN_MAX) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + LEN_W'(1);
    end
  end

  // Match counter next value; a clear wins over a same-cycle match
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_clr || cfg_load) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (z_s && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Active configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r <= PAT_RST;
      len_r <= LEN_RST;
      ovl_r <= 1'b1;
    end else if (cfg_load) begin
      pat_r <= cfg_pattern;
      len_r <= len_clamp_s;
      ovl_r <= cfg_overlap;
    end else begin
      pat_r <= pat_r;
      len_r <= len_r;
      ovl_r <= ovl_r;
    end
  end

  // History shift register and fill counter; a config load wipes both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= {MAX_LEN{1'b0}};
      fill_r <= {LEN_W{1'b0}};
    end else if (cfg_load) begin
      hist_r <= {MAX_LEN{1'b0}};
      fill_r <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      hist_r <= window_s;
      fill_r <= fill_next_s;
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  // Registered match flag and match counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      z_q_r <= z_s;
      cnt_r <= cnt_next_s;
    end
  end

  assign z           = z_s;
  assign z_q         = z_q_r;
  assign match_count = cnt_r;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog (MAX_LEN=8, CNT_W=2 so saturation is reachable).
module tb_seq_detector_prog;

  logic       clk;
  logic       rst_n;
  logic       x;
  logic       x_valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       z;
  logic       z_q;
  logic [1:0] match_count;

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .z(z), .z_q(z_q), .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       zq;
    logic [1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] m_pat;
  int         m_len;
  logic       m_ovl;
  logic [7:0] m_hist;
  int         m_fill;
  int         m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'b0000_0110; m_len = 4; m_ovl = 1'b1;
    m_hist = 8'h00; m_fill = 0; m_cnt = 0;
  endtask

  function automatic logic model_z(input logic bx, input logic bv, input logic bld);
    logic ok;
    logic w;
    if (!bv || bld || m_len == 0 || m_fill < m_len - 1) return 1'b0;
    ok = 1'b1;
    for (int i = 0; i < m_len; i++) begin
      w = (i == 0) ? bx : m_hist[i-1];
      if (w != m_pat[i]) ok = 1'b0;
    end
    return ok;
  endfunction

  // One clock: drive at negedge, check z, push expectations, check after posedge
  task automatic step(input logic bx, input logic bv, input logic bld, input logic bclr,
                      input logic [7:0] p, input logic [3:0] l, input logic o,
                      output logic zo);
    logic ez;
    exp_t e;
    x = bx; x_valid = bv; cfg_load = bld; cnt_clr = bclr;
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    #1;
    ez = model_z(bx, bv, bld);
    check_eq("z", {31'd0, z}, {31'd0, ez});
    zo = z;
    if (bld) begin
      m_pat = p; m_len = (l > 4'd8) ? 8 : int'(l); m_ovl = o;
      m_hist = 8'h00; m_fill = 0; m_cnt = 0;
    end else begin
      if (bv) begin
        m_hist = {m_hist[6:0], bx};
        if (ez && !m_ovl) m_fill = 0;
        else if (m_fill < 8) m_fill++;
      end
      if (bclr) m_cnt = 0;
      else if (ez && m_cnt < 3) m_cnt++;
    end
    e.zq = ez; e.cnt = 2'(m_cnt);
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    check_eq("z_q", {31'd0, z_q}, {31'd0, e.zq});
    check_eq("match_count", {30'd0, match_count}, {30'd0, e.cnt});
    @(negedge clk);
    x_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    logic zo;
    step(1'b0, 1'b0, 1'b1, 1'b0, p, l, o, zo);
  endtask

  // Send n bits MSB first; zv collects observed z, first bit in the highest position
  task automatic send(input logic [31:0] bits, input int n, input int gap, output logic [31:0] zv);
    logic zo;
    zv = 32'd0;
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, zo);
      zv = {zv[30:0], zo};
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, zo);
    end
  endtask

  initial begin
    logic [31:0] zv;
    logic        zo;
    rst_n = 1'b0; x = 1'b0; x_valid = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    model_reset();
    #2;
    check_eq("rst_z", {31'd0, z}, 32'd0);
    check_eq("rst_z_q", {31'd0, z_q}, 32'd0);
    check_eq("rst_cnt", {30'd0, match_count}, 32'd0);
    x_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Default overlapping 0110
    send(32'b10110110010, 11, 0, zv);
    check_eq("ovl_zv", zv, 32'h048);
    check_eq("ovl_cnt", {30'd0, match_count}, 32'd2);

    // Async reset mid-pattern: 0,1,1 then the completing 0 is on x when reset hits
    send(32'b011, 3, 0, zv);
    x = 1'b0; x_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_z", {31'd0, z}, 32'd0);
    check_eq("arst_z_q", {31'd0, z_q}, 32'd0);
    check_eq("arst_cnt", {30'd0, match_count}, 32'd0);
    #1 rst_n = 1'b1;
    x_valid = 1'b0;
    model_reset();
    send(32'b0, 1, 0, zv);
    check_eq("arst_zv", zv, 32'h0);

    // Non-overlap
    load(8'h06, 4'd4, 1'b0);
    send(32'b10110110010, 11, 0, zv);
    check_eq("novl_zv", zv, 32'h040);
    check_eq("novl_cnt", {30'd0, match_count}, 32'd1);

    // Length 8 with gapped valid
    load(8'hA5, 4'd8, 1'b1);
    send(32'hA5, 8, 2, zv);
    check_eq("gap_zv", zv, 32'h01);

    // Length 0 disables detection
    load(8'h06, 4'd0, 1'b1);
    send(32'b0110, 4, 0, zv);
    check_eq("len0_zv", zv, 32'h0);

    // Length 15 clamps to 8
    load(8'hA5, 4'd15, 1'b1);
    send(32'hA5, 8, 0, zv);
    check_eq("len15_zv", zv, 32'h01);

    // Length 1, pattern 1
    load(8'h01, 4'd1, 1'b1);
    send(32'b1101, 4, 0, zv);
    check_eq("len1_zv", zv, 32'b1101);

    // Saturation at 3 (count is already 3 here; keep matching)
    send(32'b11111, 5, 0, zv);
    check_eq("sat_cnt", {30'd0, match_count}, 32'd3);

    // cnt_clr on a match cycle
    load(8'h06, 4'd4, 1'b1);
    send(32'b011, 3, 0, zv);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, zo);
    check_eq("clr_z", {31'd0, zo}, 32'd1);
    check_eq("clr_cnt", {30'd0, match_count}, 32'd0);

    // cfg_load on the completing bit
    send(32'b011011, 6, 0, zv);
    check_eq("ld_pre_cnt", {30'd0, match_count}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h06, 4'd4, 1'b1, zo);
    check_eq("ld_z", {31'd0, zo}, 32'd0);
    check_eq("ld_cnt", {30'd0, match_count}, 32'd0);
    send(32'b0110, 4, 0, zv);
    check_eq("ld_post_zv", zv, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
